// File: rtl/arb_rr2.sv
// Two-requester round-robin arbiter with a bounded hold time, a mandatory one-cycle
// gap between grants, and a registered pulse flagging timeout revocations.
module arb_rr2 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] request,
  output logic [1:0] grant,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_HOLD);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("arb_rr2: MAX_HOLD must be in 2..255");
    end
  endgenerate

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       preempt_d;
  logic [1:0] grant_d;
  logic       cur, own_req, other_req;

  // State register; last-served resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign cur       = (state_q == GNT1);
  assign own_req   = request[cur];
  assign other_req = request[~cur];

  // Next-state logic; release is checked before timeout so it wins on the same edge.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      GNT0, GNT1: begin
        if (!own_req) begin
          state_d = GAP;
          hold_d  = '0;
        end else if (hold_q == MAX_CNT && other_req) begin
          state_d   = GAP;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (hold_q != MAX_CNT) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        hold_d = '0;
        case (request)
          2'b01: begin
            state_d = GNT0;
            last_d  = 1'b0;
            hold_d  = 8'd1;
          end
          2'b10: begin
            state_d = GNT1;
            last_d  = 1'b1;
            hold_d  = 8'd1;
          end
          2'b11: begin
            state_d = last_q ? GNT0 : GNT1;
            last_d  = ~last_q;
            hold_d  = 8'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    endcase
  end

  // Grant decoded from the next state so that the grant register tracks the state register.
  always_comb begin
    grant_d = '0;
    case (state_d)
      GNT0:    grant_d = 2'b01;
      GNT1:    grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant   <= '0;
      preempt <= 1'b0;
    end else begin
      grant   <= grant_d;
      preempt <= preempt_d;
    end
  end

endmodule

// File: doc/arb_rr2.md
ARB_RR2 -- requirements
Module: arb_rr2

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 8, maximum consecutive cycles a holder keeps grant while the other requester waits (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: request  input  2  request[i] high = requester i wants the resource; held high for the whole transaction.
REQ-005 SHALL have port: grant  output  2  registered grant, one-hot or 2'b00.
REQ-006 SHALL have port: preempt  output  1  registered one-cycle pulse marking a MAX_HOLD timeout revocation.

Function
REQ-007 SHALL implement FSM states IDLE, GNT0, GNT1, GAP; grant = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE and GAP.
REQ-008 SHALL never drive grant = 2'b11 in any cycle, including reset exit.
REQ-009 SHALL keep a last-served pointer, 1 bit, updated on entry to GNT0 (->0) or GNT1 (->1).
REQ-010 SHALL, in IDLE or GAP, sample request at the edge: 2'b00 -> IDLE; only one bit set -> that GNTx; 2'b11 -> GNTx for x != last-served.
REQ-011 SHALL have 1-cycle latency: request sampled at edge N visible as grant after edge N.
REQ-012 SHALL keep an 8-bit hold counter: loaded 1 on entering GNTx, +1 per cycle in GNTx, saturating at MAX_HOLD.
REQ-013 SHALL, in GNTx with request[x] low at the edge, go to GAP (grant 2'b00 for exactly one cycle), preempt stays 0.
REQ-014 SHALL, in GNTx with request[x] high, counter == MAX_HOLD and request of the other requester high, go to GAP and assert preempt for that GAP cycle only.
REQ-015 SHALL, in GNTx with request[x] high and other request low, stay in GNTx indefinitely, counter saturated, no preempt.
REQ-016 SHALL give release (REQ-013) priority over timeout (REQ-014) when both apply at the same edge: preempt = 0.
REQ-017 SHALL insert exactly one GAP cycle between any two grants, including a re-grant to the same requester.
REQ-018 SHALL treat request changes during GAP per REQ-010 at the edge ending GAP; request 2'b00 there -> IDLE.
REQ-019 SHALL keep preempt 0 in all cycles except the GAP cycle entered via REQ-014.

Reset
REQ-020 SHALL, while reset low, asynchronously force state IDLE, grant = 2'b00, preempt = 0, counter = 0, last-served = 1 (requester 0 wins first tie).
REQ-021 SHALL, on reset assertion mid-grant, drop grant to 2'b00 without waiting for a clock edge.
REQ-022 SHALL evaluate requests at the first rising edge with reset high, per REQ-010.

Verification (MAX_HOLD = 4)
REQ-023 SHALL cover: reset released, request = 2'b11 before edge 1 -> grant = 2'b01 after edge 1, preempt = 0.
REQ-024 SHALL cover: request = 2'b11, req0 drops after 2 grant cycles -> grant sequence 01, 01, 00, 10; preempt stays 0.
REQ-025 SHALL cover: request = 2'b11 held constant -> grant 01 x4, 00 (preempt = 1), 10 x4, 00 (preempt = 1), 01 ... repeating.
REQ-026 SHALL cover: request = 2'b01 held 12 cycles -> grant = 01 for all 12 cycles after first edge, preempt never 1.
REQ-027 SHALL cover: reset asserted mid-GNT1 -> grant 2'b00 same cycle; released with request = 2'b11 -> grant = 2'b01 after first edge.
REQ-028 SHALL cover: release and timeout at same edge (req0 drops on 4th held cycle, req1 high) -> GAP with preempt = 0, then grant = 2'b10.
